pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC sequencer for the single-cycle MIPS core, replacing the inline PC register and next-PC mux in the CPU top. It owns the PC, the exception PC (EPC) and an N-channel vectored interrupt controller, and honours a pipeline stall. The kernel/user mode is PC bit AW-1. Control decode feeds it; instruction memory, the ALU branch flag and the register file are its consumers and producers.

## Interface
- AW, 32: address width; bit AW-1 is the kernel flag.
- N_IRQ, 4: interrupt channels, 1..16.
- RESET_VEC, 32'h8000_0000: PC after reset.
- EXC_VEC, 32'h8000_0008: exception handler entry.
- IRQ_VEC_BASE, 32'h8000_0010: vector for channel 0.
- IRQ_VEC_STRIDE, 4: byte spacing between channel vectors.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  holds PC, EPC and irq_ack. Pending capture continues during a stall.
- pc_src  in  3  0 seq, 1 branch, 2 jump, 3 jr, 4 eret.
- branch_cond  in  1  ALU compare result (ALU_out[0]).
- imm16  in  16  branch offset, sign-extended, in words.
- jidx  in  26  jump index.
- jr_addr  in  AW  rs register value.
- exc_req  in  1  undefined-opcode or syscall request from decode.
- irq  in  N_IRQ  device interrupt lines, synchronous to clk.
- pc  out  AW  current PC.
- pc_plus_4  out  AW  pc + 4, for link writes.
- epc  out  AW  saved return address, for the $26 write.
- kernel  out  1  pc[AW-1].
- irq_taken  out  1  combinational: this cycle's instruction is squashed.
- exc_taken  out  1  combinational: exception redirect this cycle.
- irq_ack  out  N_IRQ  registered one-hot acknowledge.

## Operation
Priority, evaluated every cycle with stall=0, highest first:
- **Exception.** exc_req=1 gives exc_taken=1 and pc←EXC_VEC. epc←pc_plus_4 only if kernel=0; in kernel mode EPC is preserved.
- **Interrupt.** Taken when kernel=0, exc_req=0 and the source vector is non-zero.
  - Lowest channel index wins.
  - irq_taken=1 and epc←pc, so the squashed instruction is re-executed.
  - pc←IRQ_VEC_BASE + idx*IRQ_VEC_STRIDE.
  - Next cycle irq_ack has bit idx set for exactly one cycle.
- **eret** (pc_src=4): pc←epc.
- **branch** (pc_src=1): pc←pc_plus_4 + (sext(imm16)<<2) if branch_cond=1, else pc_plus_4.
- **jump** (pc_src=2): pc←{pc_plus_4[AW-1:28], jidx, 2'b00}.
- **jr** (pc_src=3): pc←jr_addr. In user mode bit AW-1 is forced to 0, so jr cannot enter kernel mode.
- **seq** (pc_src=0) and codes 5–7: pc←pc_plus_4.

Arithmetic and gating rules:
- All addition is modulo 2^AW. Branch wrap-around is not flagged.
- While kernel=1, interrupts are masked and stay pending.
- With stall=1, irq_taken and exc_taken are 0 and no state updates except the pending capture.
- exc_req and an interrupt in the same cycle: the exception wins and the interrupt stays pending.

## Timing
- Reset values: pc=RESET_VEC, epc=0, irq_ack=0, pending=0, kernel=1.
- Asynchronous assert. The first fetch after deassertion is RESET_VEC.
- next-PC is combinational and registered at the edge. The redirect takes effect on the next fetch, with zero bubble.
- irq_taken and exc_taken are valid in the same cycle as the squashed instruction, so control suppresses RegWrite and MemWrite with them.
- irq_ack lags irq_taken by one cycle.
- Reset asserted mid-handler discards EPC and pending state.

## Configuration
- PC_SEQ_IRQ_LATCH_EN defined:
  - Each channel has a sticky pending bit, set on a rising edge of irq.
  - The bit is cleared on its irq_ack.
  - Edges arriving while the bit is set merge into it.
- Undefined:
  - Sources are level-sensitive: the source vector is irq directly, with no pending register.
  - The device must hold the line until it sees the ack.

## Structure
- Package pc_seq_pkg holds:
  - pc_src encoding constants (PCS_SEQ, PCS_BR, PCS_J, PCS_JR, PCS_ERET);
  - the default vector constants;
  - the max-N_IRQ check.
- Sub-module pc_seq_prio_enc: parametrised N_IRQ lowest-index-first priority encoder, outputs valid and idx.

## Test plan
- Reset release with pc_src=0 for 3 cycles → pc goes 8000_0000, 8000_0004, 8000_0008.
- In user mode at pc=0000_0100, irq=4'b0110 → irq_taken=1, pc=8000_0014, epc=0000_0100, irq_ack=4'b0010 next cycle; after eret, channel 2 is taken once back in user mode.
- exc_req and irq[0] together at pc=0000_0200 → pc=8000_0008, epc=0000_0204, irq_ack=0, irq[0] still pending.
- Branch at pc=0000_0000 with imm16=16'hFFFF and branch_cond=1 → pc=0000_0000. jr in user mode with jr_addr=8000_0040 → pc=0000_0040.
- stall=1 for 3 cycles while irq[3] pulses for 1 cycle (latch enabled) → pc is held; after stall falls, channel 3 is taken with vector 8000_001C.
- Reset asserted in a handler with epc=0000_0300 → epc=0 and pc=8000_0000 immediately.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared constants for the next-PC sequencer: pc_src encodings, default
// vectors and the interrupt channel count limits.
package pc_seq_pkg;

  localparam int unsigned PCS_W = 3;

  localparam logic [PCS_W-1:0] PCS_SEQ  = 3'd0;
  localparam logic [PCS_W-1:0] PCS_BR   = 3'd1;
  localparam logic [PCS_W-1:0] PCS_J    = 3'd2;
  localparam logic [PCS_W-1:0] PCS_JR   = 3'd3;
  localparam logic [PCS_W-1:0] PCS_ERET = 3'd4;

  localparam logic [31:0] DEF_RESET_VEC      = 32'h8000_0000;
  localparam logic [31:0] DEF_EXC_VEC        = 32'h8000_0008;
  localparam logic [31:0] DEF_IRQ_VEC_BASE   = 32'h8000_0010;
  localparam int unsigned DEF_IRQ_VEC_STRIDE = 4;

  localparam int unsigned MAX_N_IRQ = 16;

  // Legal channel count: 1..MAX_N_IRQ.
  function automatic bit n_irq_ok(input int unsigned n);
    return (n >= 1) && (n <= MAX_N_IRQ);
  endfunction

  // Index width for an n-channel encoder (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_seq_prio_enc.sv
// Lowest-index-first priority encoder.
//   req   : request vector
//   valid : any request present
//   idx   : index of the lowest set request bit (0 when none)
module pc_seq_prio_enc
  import pc_seq_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: owns PC, EPC and an N_IRQ-channel vectored interrupt
// controller; kernel mode is pc[AW-1].
// Build option: PC_SEQ_IRQ_LATCH_EN -- sticky, rising-edge pending bits per
// channel; otherwise irq lines are level-sensitive and used directly.
// Ports:
//   clk, reset (async, active-low)
//   stall            : hold PC/EPC/irq_ack (pending capture continues)
//   pc_src           : 0 seq, 1 branch, 2 jump, 3 jr, 4 eret, 5-7 seq
//   branch_cond, imm16, jidx, jr_addr : redirect operands
//   exc_req, irq     : exception request, interrupt lines
//   pc, pc_plus_4, epc, kernel        : architectural state views
//   irq_taken, exc_taken              : combinational squash/redirect flags
//   irq_ack          : registered one-hot acknowledge, one cycle after take
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned    AW             = 32,
  parameter int unsigned    N_IRQ          = 4,
  parameter logic [AW-1:0]  RESET_VEC      = AW'(DEF_RESET_VEC),
  parameter logic [AW-1:0]  EXC_VEC        = AW'(DEF_EXC_VEC),
  parameter logic [AW-1:0]  IRQ_VEC_BASE   = AW'(DEF_IRQ_VEC_BASE),
  parameter int unsigned    IRQ_VEC_STRIDE = DEF_IRQ_VEC_STRIDE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [PCS_W-1:0]  pc_src,
  input  logic              branch_cond,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jidx,
  input  logic [AW-1:0]     jr_addr,
  input  logic              exc_req,
  input  logic [N_IRQ-1:0]  irq,
  output logic [AW-1:0]     pc,
  output logic [AW-1:0]     pc_plus_4,
  output logic [AW-1:0]     epc,
  output logic              kernel,
  output logic              irq_taken,
  output logic              exc_taken,
  output logic [N_IRQ-1:0]  irq_ack
);

  localparam int unsigned IW = idx_w(N_IRQ);

  if (!n_irq_ok(N_IRQ)) begin : g_bad_n_irq
    $error("pc_sequencer: N_IRQ must be in 1..16");
  end

  logic [N_IRQ-1:0] irq_src;
  logic             irq_valid;
  logic [IW-1:0]    irq_idx;
  logic [AW-1:0]    pc_next;
  logic [AW-1:0]    epc_next;
  logic [N_IRQ-1:0] ack_next;
  logic [AW-1:0]    br_off;
  logic [AW-1:0]    jr_tgt;

  assign pc_plus_4 = pc + AW'(4);
  assign kernel    = pc[AW-1];

`ifdef PC_SEQ_IRQ_LATCH_EN
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] irq_rise;

  assign irq_rise = irq & ~irq_q;
  // A fresh edge is visible in the cycle it arrives, not only once latched.
  assign irq_src  = pending | irq_rise;

  // Pending capture runs regardless of stall; a new edge beats the ack clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~irq_ack) | irq_rise;
    end
  end
`else
  assign irq_src = irq;
`endif

  pc_seq_prio_enc #(
    .N  (N_IRQ),
    .IW (IW)
  ) u_prio (
    .req   (irq_src),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  // Squash/redirect flags for the instruction currently at pc.
  always_comb begin
    exc_taken = 1'b0;
    irq_taken = 1'b0;
    if (!stall) begin
      exc_taken = exc_req;
      irq_taken = !exc_req && !kernel && irq_valid;
    end
  end

  // Next-PC, next-EPC and next-ack selection.
  always_comb begin
    br_off   = {{(AW-18){imm16[15]}}, imm16, 2'b00};
    jr_tgt   = jr_addr;
    pc_next  = pc_plus_4;
    epc_next = epc;
    ack_next = '0;

    // User-mode jr may not set the kernel bit.
    if (!kernel) jr_tgt[AW-1] = 1'b0;

    if (exc_taken) begin
      pc_next = EXC_VEC;
      if (!kernel) epc_next = pc_plus_4;
    end else if (irq_taken) begin
      pc_next  = IRQ_VEC_BASE + AW'(irq_idx) * AW'(IRQ_VEC_STRIDE);
      epc_next = pc;
      ack_next = N_IRQ'(1) << irq_idx;
    end else begin
      case (pc_src)
        PCS_BR:   pc_next = branch_cond ? (pc_plus_4 + br_off) : pc_plus_4;
        PCS_J:    pc_next = (pc_plus_4 & ~AW'(28'hFFF_FFFF)) | AW'({jidx, 2'b00});
        PCS_JR:   pc_next = jr_tgt;
        PCS_ERET: pc_next = epc;
        default:  pc_next = pc_plus_4;
      endcase
    end
  end

  // Architectural state; stall freezes everything here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_VEC;
      epc     <= '0;
      irq_ack <= '0;
    end else if (!stall) begin
      pc      <= pc_next;
      epc     <= epc_next;
      irq_ack <= ack_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes the expected per-cycle
// view (pc, epc, irq_ack, takens) and a negedge monitor pops and compares.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

`ifdef PC_SEQ_IRQ_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  pc_src = PCS_SEQ;
  logic        branch_cond = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] jidx = '0;
  logic [31:0] jr_addr = '0;
  logic        exc_req = 1'b0;
  logic [3:0]  irq = '0;
  logic [31:0] pc, pc_plus_4, epc;
  logic        kernel, irq_taken, exc_taken;
  logic [3:0]  irq_ack;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .pc_src      (pc_src),
    .branch_cond (branch_cond),
    .imm16       (imm16),
    .jidx        (jidx),
    .jr_addr     (jr_addr),
    .exc_req     (exc_req),
    .irq         (irq),
    .pc          (pc),
    .pc_plus_4   (pc_plus_4),
    .epc         (epc),
    .kernel      (kernel),
    .irq_taken   (irq_taken),
    .exc_taken   (exc_taken),
    .irq_ack     (irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [3:0]  ack;
    logic        it;
    logic        et;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per sampled cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("pc",        pc,               mon_e.pc);
      chk("pc_plus_4", pc_plus_4,        mon_e.pc + 32'd4);
      chk("kernel",    32'(kernel),      32'(mon_e.pc[31]));
      chk("epc",       epc,              mon_e.epc);
      chk("irq_ack",   32'(irq_ack),     32'(mon_e.ack));
      chk("irq_taken", 32'(irq_taken),   32'(mon_e.it));
      chk("exc_taken", 32'(exc_taken),   32'(mon_e.et));
    end
  end

  // Push this cycle's expectation, then advance past the next rising edge.
  task automatic cyc(input logic [31:0] p, input logic [31:0] e, input logic [3:0] a,
                     input logic it, input logic et);
    sb.push_back('{pc: p, epc: e, ack: a, it: it, et: et});
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    // Reset release, sequential fetch.
    cyc(32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b0);
    cyc(32'h8000_0004, 32'h0, 4'h0, 1'b0, 1'b0);
    pc_src = PCS_JR; jr_addr = 32'h0000_0100;
    cyc(32'h8000_0008, 32'h0, 4'h0, 1'b0, 1'b0);
    // User mode: channels 1 and 2 request, channel 1 wins.
    pc_src = PCS_SEQ; irq = 4'b0110;
    cyc(32'h0000_0100, 32'h0, 4'h0, 1'b1, 1'b0);
    irq = 4'b0100;
    cyc(32'h8000_0014, 32'h100, 4'b0010, 1'b0, 1'b0);
    pc_src = PCS_ERET;
    cyc(32'h8000_0018, 32'h100, 4'h0, 1'b0, 1'b0);
    pc_src = PCS_SEQ;
    cyc(32'h0000_0100, 32'h100, 4'h0, 1'b1, 1'b0);
    irq = 4'b0000;
    cyc(32'h8000_0018, 32'h100, 4'b0100, 1'b0, 1'b0);
    // Exception and interrupt together in user mode.
    pc_src = PCS_JR; jr_addr = 32'h0000_0200;
    cyc(32'h8000_001C, 32'h100, 4'h0, 1'b0, 1'b0);
    pc_src = PCS_SEQ; exc_req = 1'b1; irq = 4'b0001;
    cyc(32'h0000_0200, 32'h100, 4'h0, 1'b0, 1'b1);
    exc_req = 1'b0;
    cyc(32'h8000_0008, 32'h204, 4'h0, 1'b0, 1'b0);
    pc_src = PCS_ERET;
    cyc(32'h8000_000C, 32'h204, 4'h0, 1'b0, 1'b0);
    pc_src = PCS_SEQ;
    cyc(32'h0000_0204, 32'h204, 4'h0, 1'b1, 1'b0);
    irq = 4'b0000;
    cyc(32'h8000_0010, 32'h204, 4'b0001, 1'b0, 1'b0);
    // Kernel-mode exception keeps EPC.
    exc_req = 1'b1;
    cyc(32'h8000_0014, 32'h204, 4'h0, 1'b0, 1'b1);
    exc_req = 1'b0; pc_src = PCS_JR; jr_addr = 32'h0;
    cyc(32'h8000_0008, 32'h204, 4'h0, 1'b0, 1'b0);
    // Branches, jr kernel-bit clamp, jump, undefined code.
    pc_src = PCS_BR; imm16 = 16'hFFFF; branch_cond = 1'b1;
    cyc(32'h0000_0000, 32'h204, 4'h0, 1'b0, 1'b0);
    imm16 = 16'h0010; branch_cond = 1'b0;
    cyc(32'h0000_0000, 32'h204, 4'h0, 1'b0, 1'b0);
    branch_cond = 1'b1;
    cyc(32'h0000_0004, 32'h204, 4'h0, 1'b0, 1'b0);
    pc_src = PCS_JR; jr_addr = 32'h8000_0040;
    cyc(32'h0000_0048, 32'h204, 4'h0, 1'b0, 1'b0);
    pc_src = PCS_J; jidx = 26'h000_0123;
    cyc(32'h0000_0040, 32'h204, 4'h0, 1'b0, 1'b0);
    pc_src = 3'd5;
    cyc(32'h0000_048C, 32'h204, 4'h0, 1'b0, 1'b0);
    // Stall while channel 3 requests (pulse if latched, held if level).
    pc_src = PCS_SEQ; stall = 1'b1; irq = 4'b1000;
    cyc(32'h0000_0490, 32'h204, 4'h0, 1'b0, 1'b0);
    exc_req = 1'b1; irq = LATCH ? 4'b0000 : 4'b1000;
    cyc(32'h0000_0490, 32'h204, 4'h0, 1'b0, 1'b0);
    exc_req = 1'b0;
    cyc(32'h0000_0490, 32'h204, 4'h0, 1'b0, 1'b0);
    stall = 1'b0;
    cyc(32'h0000_0490, 32'h204, 4'h0, 1'b1, 1'b0);
    irq = 4'b0000;
    cyc(32'h8000_001C, 32'h490, 4'b1000, 1'b0, 1'b0);
    cyc(32'h8000_0020, 32'h490, 4'h0, 1'b0, 1'b0);
    // Asynchronous reset inside the handler.
    reset = 1'b0;
    sb.push_back('{pc: 32'h8000_0000, epc: 32'h0, ack: 4'h0, it: 1'b0, et: 1'b0});
    @(negedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b0);
    cyc(32'h8000_0004, 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

endmodule
